// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the async_fifo packet writer and its read-side checker.
package fifo_pkt_pkg;

  // Writer sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CKSUM   = 2'd2
  } pkt_wr_state_t;

  // Widest checksum the helper supports; callers keep the low DATA_WIDTH bits.
  localparam int unsigned CKSUM_MAX_W = 64;

  // Two's complement of the running sum, so payload + checksum == 0 mod 2^W.
  // Truncating the 64-bit negation to any narrower width gives the same result.
  function automatic logic [CKSUM_MAX_W-1:0] cksum_fn(input logic [CKSUM_MAX_W-1:0] sum);
    return -sum;
  endfunction

endpackage

// File: rtl/fifo_wr_skid.sv
// One-entry holding register in front of the async_fifo write port.
// A word may load while the previous one drains in the same cycle.
module fifo_wr_skid
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  full,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_tag,
  output logic                  can_load,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  tag_written
);

  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_tag_q, hold_tag_d;

  assign wr_en       = hold_vld_q & ~full;
  assign can_load    = ~hold_vld_q | wr_en;
  assign din         = hold_data_q;
  assign tag_written = wr_en & hold_tag_q;

  // Next holding-register contents: load wins, otherwise a write empties it.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_tag_d  = hold_tag_q;
    if (load) begin
      hold_vld_d  = 1'b1;
      hold_data_d = ld_data;
      hold_tag_d  = ld_tag;
    end else if (wr_en) begin
      hold_vld_d  = 1'b0;
      hold_tag_d  = 1'b0;
    end
  end

  // Holding register flops.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_tag_q  <= 1'b0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_tag_q  <= hold_tag_d;
    end
  end

endmodule

// File: rtl/fifo_pkt_writer.sv
// Write-side producer for async_fifo: forwards payload words and appends a
// zero-sum checksum word after every packet.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for the first word of a packet
//   PAYLOAD | accumulating further words until s_last or MAX_LEN
//   CKSUM   | upstream stalled; checksum loads as soon as the register frees
module fifo_pkt_writer
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  pkt_done,
  output logic                  len_err,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);

  pkt_wr_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;

  logic                  load;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_tag;
  logic                  can_load;
  logic                  tag_written;
  logic                  accept;
  logic                  len_err_c;
  logic [LEN_W-1:0]      len_inc;
  logic [CKSUM_MAX_W-1:0] cksum_w;

  fifo_wr_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .full        (full),
    .load        (load),
    .ld_data     (ld_data),
    .ld_tag      (ld_tag),
    .can_load    (can_load),
    .wr_en       (wr_en),
    .din         (din),
    .tag_written (tag_written)
  );

  // Reset is folded in so s_ready reads 0 while rst is held, even though the
  // register is empty and the state is IDLE.
  assign s_ready   = ~rst & (state_q != CKSUM) & can_load;
  assign accept    = s_valid & s_ready;
  assign len_inc   = len_q + LEN_W'(1);
  assign cksum_w   = cksum_fn(CKSUM_MAX_W'(sum_q));
  assign pkt_done  = tag_written;
  assign len_err   = len_err_c;
  assign pkt_count = pkt_count_q;

  // Packet sequencing, running sum and register load control.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    len_d       = len_q;
    load        = 1'b0;
    ld_data     = s_data;
    ld_tag      = 1'b0;
    len_err_c   = 1'b0;
    pkt_count_d = pkt_count_q + CNT_WIDTH'(tag_written);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load  = 1'b1;
          sum_d = s_data;
          len_d = LEN_W'(1);
          if (s_last || MAX_LEN == 1) begin
            state_d   = CKSUM;
            len_err_c = ~s_last;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          load  = 1'b1;
          sum_d = sum_q + s_data;
          len_d = len_inc;
          if (s_last || len_inc == LEN_LIMIT) begin
            state_d   = CKSUM;
            len_err_c = ~s_last;
          end
        end
      end
      CKSUM: begin
        if (can_load) begin
          load    = 1'b1;
          ld_data = cksum_w[DATA_WIDTH-1:0];
          ld_tag  = 1'b1;
          sum_d   = '0;
          len_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, sum, length and packet counter flops.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      len_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      len_q       <= len_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Scoreboard bench for fifo_pkt_writer: a packet-level model queues the
// expected FIFO words, a monitor pops and compares on every write.
module tb_fifo_pkt_writer;

  localparam int DW      = 8;
  localparam int MAX_LEN = 16;
  localparam int CW      = 16;

  logic          wr_clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          full = 1'b0;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          pkt_done;
  logic          len_err;
  logic [CW-1:0] pkt_count;

  fifo_pkt_writer #(.DATA_WIDTH(DW), .MAX_LEN(MAX_LEN), .CNT_WIDTH(CW)) dut (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .full      (full),
    .wr_en     (wr_en),
    .din       (din),
    .pkt_done  (pkt_done),
    .len_err   (len_err),
    .pkt_count (pkt_count)
  );

  always #5 wr_clk = ~wr_clk;

  int n_pass = 0;
  int n_total = 0;

  // Expected FIFO words: bit 8 marks the checksum word.
  logic [8:0] exp_q[$];
  int         m_cnt = 0;
  int         m_sum = 0;
  int         exp_count = 0;
  bit         rand_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: packet rules applied at each accepted word.
  always @(negedge wr_clk) begin
    if (!rst) begin
      bit exp_le;
      exp_le = 1'b0;
      if (s_valid && s_ready) begin
        m_cnt++;
        m_sum += int'(s_data);
        exp_q.push_back({1'b0, s_data});
        if (s_last || m_cnt == MAX_LEN) begin
          exp_le = !s_last;
          exp_q.push_back({1'b1, 8'((256 - (m_sum % 256)) % 256)});
          m_cnt = 0;
          m_sum = 0;
        end
      end
      chk("len_err", len_err, exp_le);
    end
  end

  // Monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge wr_clk) begin
    if (!rst) begin
      logic [8:0] e;
      chk("pkt_count", pkt_count, exp_count);
      if (full) chk("no_write_when_full", wr_en, 1'b0);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got din=%0h expected no write at %0t", din, $time);
        end else begin
          e = exp_q.pop_front();
          chk("din", din, e[7:0]);
          chk("pkt_done", pkt_done, e[8]);
          if (e[8]) exp_count++;
        end
      end else begin
        chk("pkt_done_idle", pkt_done, 1'b0);
      end
    end
  end

  // Random backpressure from the FIFO when enabled.
  always @(posedge wr_clk) begin
    #1;
    if (rand_full) full = ($urandom_range(0, 3) == 0);
  end

  task automatic send_word(input logic [7:0] d, input logic l, output int stalls);
    int  t;
    bit  done;
    stalls  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    t    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge wr_clk);
      if (s_ready) done = 1'b1;
      else begin
        stalls++;
        t++;
        if (t > 200) begin
          n_total++;
          $display("FAIL accept_timeout: got no s_ready expected accept of %0h", d);
          done = 1'b1;
        end
      end
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  initial begin
    int st;
    int tot;
    #12;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_din", din, 8'h00);
    chk("rst_pkt_count", pkt_count, 16'h0);
    chk("rst_len_err", len_err, 1'b0);
    @(posedge wr_clk);
    #1 rst = 1'b0;
    idle(2);

    // 01,02,03 -> 01,02,03,FA
    send_word(8'h01, 1'b0, st);
    send_word(8'h02, 1'b0, st);
    send_word(8'h03, 1'b1, st);
    idle(4);
    chk("pkt_count_after_first", pkt_count, 16'd1);

    // single-word packet 80 -> 80,80
    send_word(8'h80, 1'b1, st);
    idle(4);

    // 17 words without last: checksum forced after 0F, 10 opens a new packet
    for (int i = 0; i < 17; i++) send_word(8'(i), 1'b0, st);
    send_word(8'h11, 1'b1, st);
    idle(4);

    // full held 5 cycles mid-packet
    send_word(8'h21, 1'b0, st);
    full    = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h22;
    s_last  = 1'b0;
    repeat (5) begin
      @(negedge wr_clk);
      chk("full_hold_wr_en", wr_en, 1'b0);
      chk("full_hold_s_ready", s_ready, 1'b0);
    end
    @(posedge wr_clk);
    #1 full = 1'b0;
    send_word(8'h22, 1'b0, st);
    send_word(8'h23, 1'b1, st);
    idle(4);

    // back-to-back packets: one stall per packet boundary
    tot = 0;
    for (int p = 0; p < 4; p++) begin
      for (int w = 0; w < 3; w++) begin
        send_word(8'($urandom), (w == 2), st);
        tot += st;
      end
    end
    chk("b2b_stall_cycles", tot, 3);
    idle(4);

    // reset mid-packet
    send_word(8'h01, 1'b0, st);
    send_word(8'h02, 1'b0, st);
    rst     = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_s_ready", s_ready, 1'b0);
    chk("midrst_din", din, 8'h00);
    chk("midrst_pkt_count", pkt_count, 16'h0);
    chk("midrst_pkt_done", pkt_done, 1'b0);
    exp_q.delete();
    m_cnt = 0;
    m_sum = 0;
    exp_count = 0;
    @(posedge wr_clk);
    #3 rst = 1'b0;
    idle(1);
    send_word(8'h05, 1'b1, st);
    idle(4);
    chk("pkt_count_after_reset", pkt_count, 16'd1);

    // randomized traffic with random backpressure
    rand_full = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      send_word(8'($urandom), ($urandom_range(0, 5) == 0), st);
    end
    s_valid = 1'b0;
    rand_full = 1'b0;
    full = 1'b0;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge wr_clk);
    idle(2);
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
